// File: rtl/lane_burst_ram_pkg.sv
// Shared types and helpers for the lane_burst_ram parameter store.
// The sweep FSM state is exported so the top can expose it for debug.
package lane_burst_ram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Number of LANES-wide beats needed to cover n words.
    function automatic int unsigned beat_count(input int unsigned n, input int unsigned lanes);
        return (n + lanes - 1) / lanes;
    endfunction

endpackage

// File: rtl/multiread_ram_core.sv
// Register-file array with one write port and LANES combinational read ports.
// Read port i returns mem[(rd_base + i) mod RAM_DEPTH].
module multiread_ram_core #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int LANES      = 8
) (
    input  logic                        clk,
    input  logic                        wr_en,
    input  logic [ADDR_WIDTH-1:0]       wr_addr,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    input  logic [ADDR_WIDTH-1:0]       rd_base,
    output logic [LANES*DATA_WIDTH-1:0] rd_data
);

    localparam int RAM_DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    // Contents are deliberately never reset; only the fill pointer is.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The ADDR_WIDTH-bit sum wraps naturally past the top of the array.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < LANES; i++) begin
            rd_data[i*DATA_WIDTH +: DATA_WIDTH] = mem[rd_base + ADDR_WIDTH'(i)];
        end
    end

endmodule

// File: rtl/lane_burst_ram.sv
// Append-only parameter RAM with a LANES-wide burst read port, supporting
// single random bursts and an automatic sweep over all stored words.
module lane_burst_ram
    import lane_burst_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int LANES      = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        wr_en,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    output logic                        wr_done,
    output logic                        wr_err,
    output logic [ADDR_WIDTH:0]         fill_count,
    output logic                        full,
    output logic                        empty,
    input  logic                        rd_req,
    input  logic [ADDR_WIDTH-1:0]       rd_base,
    input  logic                        sweep_start,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*DATA_WIDTH-1:0] out_data,
    output logic [LANES-1:0]            out_mask,
    output logic [ADDR_WIDTH-1:0]       out_base,
    output logic                        out_last,
    output logic                        busy,
    output logic                        sweep_done,
    output state_t                      dbg_state
);

    localparam int RAM_DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW        = ADDR_WIDTH + 1;

    state_t state;

    logic [CW-1:0] fill_q;
    logic [CW-1:0] sweep_n;
    logic [CW-1:0] sweep_next;
    logic [CW-1:0] beats_left;
    logic [CW-1:0] beats_init;

    logic full_c;
    logic reg_free;
    logic hs;
    logic wr_accept;
    logic wr_reject;
    logic sweep_go;
    logic rd_go;

    logic                        load;
    logic [ADDR_WIDTH-1:0]       ld_base;
    logic [CW-1:0]               ld_limit;
    logic                        ld_last;
    logic [LANES-1:0]            ld_mask;
    logic [LANES*DATA_WIDTH-1:0] ld_data;

    // Output handshake: a beat transfers on a rising edge where out_valid and
    // out_ready are both high; out_valid never drops and the payload never
    // changes while out_valid is high and out_ready is low. The register may
    // be reloaded only when it is free (!out_valid || out_ready).
    assign reg_free = !out_valid || out_ready;
    assign hs       = out_valid && out_ready;

    assign full_c     = (fill_q == CW'(RAM_DEPTH));
    assign wr_accept  = wr_en && !full_c && (state == IDLE) && !clr;
    assign wr_reject  = wr_en && !clr && (full_c || (state != IDLE));
    assign sweep_go   = (state == IDLE) && sweep_start && !clr;
    assign rd_go      = (state == IDLE) && rd_req && !sweep_start && reg_free;
    assign beats_init = CW'(beat_count(32'(fill_q), LANES));

    assign fill_count = fill_q;
    assign full       = full_c;
    assign empty      = (fill_q == '0);
    assign dbg_state  = state;

    // Beat selection: a random burst, the first sweep beat on the start edge,
    // or the next pending sweep beat once the register frees up.
    always_comb begin
        load     = 1'b0;
        ld_base  = rd_base;
        ld_limit = fill_q;
        ld_last  = 1'b1;
        if (rd_go) begin
            load = 1'b1;
        end else if (sweep_go && (fill_q != '0) && reg_free) begin
            load    = 1'b1;
            ld_base = '0;
            ld_last = (beats_init == CW'(1));
        end else if ((state == SWEEP) && !clr && (beats_left != '0) && reg_free) begin
            load     = 1'b1;
            ld_base  = sweep_next[ADDR_WIDTH-1:0];
            ld_limit = sweep_n;
            ld_last  = (beats_left == CW'(1));
        end
    end

    // Mask is evaluated unwrapped so lanes that wrap past the top stay invalid.
    always_comb begin
        ld_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            ld_mask[i] = (({1'b0, ld_base} + CW'(i)) < ld_limit);
        end
    end

    multiread_ram_core #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .LANES     (LANES)
    ) u_core (
        .clk    (clk),
        .wr_en  (wr_accept),
        .wr_addr(fill_q[ADDR_WIDTH-1:0]),
        .wr_data(wr_data),
        .rd_base(ld_base),
        .rd_data(ld_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_q  <= '0;
            wr_done <= 1'b0;
            wr_err  <= 1'b0;
        end else begin
            wr_done <= wr_accept;
            if (clr) begin
                fill_q <= '0;
                wr_err <= 1'b0;
            end else begin
                if (wr_accept) begin
                    fill_q <= fill_q + CW'(1);
                end
                if (wr_reject) begin
                    wr_err <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_mask  <= '0;
            out_base  <= '0;
            out_last  <= 1'b0;
        end else if ((state == SWEEP) && clr) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= ld_data;
            out_mask  <= ld_mask;
            out_base  <= ld_base;
            out_last  <= ld_last;
        end else if (hs) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            sweep_done <= 1'b0;
            sweep_n    <= '0;
            sweep_next <= '0;
            beats_left <= '0;
        end else begin
            case (state)
                IDLE: begin
                    sweep_done <= 1'b0;
                    if (sweep_go) begin
                        if (fill_q == '0) begin
                            state      <= DONE;
                            sweep_done <= 1'b1;
                        end else begin
                            state   <= SWEEP;
                            busy    <= 1'b1;
                            sweep_n <= fill_q;
                            // A held random beat delays the first sweep beat.
                            if (reg_free) begin
                                sweep_next <= CW'(LANES);
                                beats_left <= beats_init - CW'(1);
                            end else begin
                                sweep_next <= '0;
                                beats_left <= beats_init;
                            end
                        end
                    end
                end
                SWEEP: begin
                    if (clr) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        beats_left <= '0;
                    end else begin
                        if (load) begin
                            sweep_next <= sweep_next + CW'(LANES);
                            beats_left <= beats_left - CW'(1);
                        end
                        if (hs && out_last && (beats_left == '0)) begin
                            state      <= DONE;
                            busy       <= 1'b0;
                            sweep_done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    sweep_done <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    sweep_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lane_burst_ram.sv
// Scenario bench for lane_burst_ram: shadow memory model plus a beat
// scoreboard checked on every output handshake.
module tb_lane_burst_ram;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int LANES = 8;
  localparam int DEPTH = 2 ** AW;
  localparam int BW    = LANES * DW + LANES + AW + 1;

  logic                  clk;
  logic                  rst;
  logic                  clr;
  logic                  wr_en;
  logic [DW-1:0]         wr_data;
  logic                  wr_done;
  logic                  wr_err;
  logic [AW:0]           fill_count;
  logic                  full;
  logic                  empty;
  logic                  rd_req;
  logic [AW-1:0]         rd_base;
  logic                  sweep_start;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*DW-1:0]   out_data;
  logic [LANES-1:0]      out_mask;
  logic [AW-1:0]         out_base;
  logic                  out_last;
  logic                  busy;
  logic                  sweep_done;
  lane_burst_ram_pkg::state_t dbg_state;

  logic [BW-1:0] exp_q[$];
  logic [DW-1:0] mem_m[DEPTH];
  int            fill_m;
  int            chk_cnt;
  int            pass_cnt;
  int            hs_cnt;

  lane_burst_ram #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .LANES     (LANES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_done    (wr_done),
    .wr_err     (wr_err),
    .fill_count (fill_count),
    .full       (full),
    .empty      (empty),
    .rd_req     (rd_req),
    .rd_base    (rd_base),
    .sweep_start(sweep_start),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_mask   (out_mask),
    .out_base   (out_base),
    .out_last   (out_last),
    .busy       (busy),
    .sweep_done (sweep_done),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- model ----------------
  function automatic logic [BW-1:0] exp_beat(input int base, input int limit, input bit last);
    logic [LANES*DW-1:0] d;
    logic [LANES-1:0]    m;
    for (int i = 0; i < LANES; i++) begin
      d[i*DW +: DW] = mem_m[(base + i) % DEPTH];
      m[i]          = ((base + i) < limit);
    end
    return {d, m, AW'(base), last};
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      logic [BW-1:0] got;
      logic [BW-1:0] e;
      got = {out_data, out_mask, out_base, out_last};
      hs_cnt++;
      chk_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected: got beat base %0d, expected no beat", out_base);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) $display("FAIL sb_beat: got %h expected %h", got, e);
        else pass_cnt++;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    fill_m = 0;
  endtask

  task automatic do_write(input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    step(1);
    wr_en = 1'b0;
    if (fill_m < DEPTH) begin
      mem_m[fill_m] = d;
      fill_m++;
    end
  endtask

  task automatic pulse_sweep();
    sweep_start = 1'b1;
    step(1);
    sweep_start = 1'b0;
  endtask

  task automatic pulse_rd(input int base);
    rd_req  = 1'b1;
    rd_base = AW'(base);
    step(1);
    rd_req = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    step(3);
    chk_cnt++;
    if ({out_valid, out_mask, out_base, out_last, wr_done, wr_err, busy, sweep_done, full, empty, fill_count}
        !== {1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0})
      $display("FAIL reset_ctrl: got v=%b m=%h b=%0d l=%b wd=%b we=%b busy=%b sd=%b full=%b empty=%b fill=%0d",
               out_valid, out_mask, out_base, out_last, wr_done, wr_err, busy, sweep_done, full, empty, fill_count);
    else pass_cnt++;
    chk_cnt++;
    if (out_data !== '0) $display("FAIL reset_data: got %h expected 0", out_data);
    else pass_cnt++;
    rst = 1'b0;
    step(1);
    chk_cnt++;
    if ({empty, fill_count, dbg_state} !== {1'b1, 6'd0, lane_burst_ram_pkg::IDLE})
      $display("FAIL post_reset_idle: got empty=%b fill=%0d state=%0d", empty, fill_count, dbg_state);
    else pass_cnt++;
  endtask

  task automatic test_full();
    do_clr();
    for (int i = 0; i < DEPTH; i++) do_write($urandom);
    chk_cnt++;
    if ({wr_done, full, empty, fill_count} !== {1'b1, 1'b1, 1'b0, 6'd32})
      $display("FAIL full_after_32: got wd=%b full=%b empty=%b fill=%0d expected 1 1 0 32", wr_done, full, empty, fill_count);
    else pass_cnt++;
    do_write(32'hDEAD_BEEF);
    chk_cnt++;
    if ({wr_done, wr_err, full, fill_count} !== {1'b0, 1'b1, 1'b1, 6'd32})
      $display("FAIL overflow_write: got wd=%b err=%b full=%b fill=%0d expected 0 1 1 32", wr_done, wr_err, full, fill_count);
    else pass_cnt++;
    step(1);
    chk_cnt++;
    if (wr_err !== 1'b1) $display("FAIL wr_err_sticky: got %b expected 1", wr_err);
    else pass_cnt++;
  endtask

  task automatic test_wrap_read();
    out_ready = 1'b1;
    exp_q.push_back(exp_beat(28, fill_m, 1'b1));
    pulse_rd(28);
    chk_cnt++;
    if ({out_valid, out_mask, out_base, out_last} !== {1'b1, 8'h0F, 5'd28, 1'b1})
      $display("FAIL wrap_read: got v=%b m=%h b=%0d l=%b expected 1 0f 28 1", out_valid, out_mask, out_base, out_last);
    else pass_cnt++;
    step(1);
    chk_cnt++;
    if (out_valid !== 1'b0) $display("FAIL wrap_read_drop: got out_valid=%b expected 0", out_valid);
    else pass_cnt++;
    out_ready = 1'b0;
  endtask

  task automatic test_read_during_write();
    do_clr();
    chk_cnt++;
    if ({wr_err, fill_count} !== {1'b0, 6'd0}) $display("FAIL clr_clears: got err=%b fill=%0d expected 0 0", wr_err, fill_count);
    else pass_cnt++;
    out_ready = 1'b1;
    exp_q.push_back(exp_beat(0, 0, 1'b1));
    wr_en   = 1'b1;
    wr_data = 32'h0000_0055;
    rd_req  = 1'b1;
    rd_base = '0;
    step(1);
    wr_en  = 1'b0;
    rd_req = 1'b0;
    mem_m[0] = 32'h0000_0055;
    fill_m = 1;
    chk_cnt++;
    if ({wr_done, out_valid, out_mask, fill_count} !== {1'b1, 1'b1, 8'h00, 6'd1})
      $display("FAIL rd_wr_same_cycle: got wd=%b v=%b m=%h fill=%0d expected 1 1 00 1", wr_done, out_valid, out_mask, fill_count);
    else pass_cnt++;
    step(1);
    out_ready = 1'b0;
  endtask

  task automatic test_sweep_basic();
    do_clr();
    for (int i = 0; i < 10; i++) do_write(32'hA0 + 32'(i));
    out_ready = 1'b1;
    exp_q.push_back(exp_beat(0, 10, 1'b0));
    exp_q.push_back(exp_beat(8, 10, 1'b1));
    pulse_sweep();
    chk_cnt++;
    if ({out_valid, busy, out_base, out_last, out_mask} !== {1'b1, 1'b1, 5'd0, 1'b0, 8'hFF})
      $display("FAIL sweep_beat1: got v=%b busy=%b b=%0d l=%b m=%h", out_valid, busy, out_base, out_last, out_mask);
    else pass_cnt++;
    step(1);
    chk_cnt++;
    if ({out_valid, busy, out_base, out_last, out_mask} !== {1'b1, 1'b1, 5'd8, 1'b1, 8'h03})
      $display("FAIL sweep_beat2: got v=%b busy=%b b=%0d l=%b m=%h", out_valid, busy, out_base, out_last, out_mask);
    else pass_cnt++;
    step(1);
    chk_cnt++;
    if ({out_valid, busy, sweep_done} !== 3'b001)
      $display("FAIL sweep_done_pulse: got v=%b busy=%b sd=%b expected 0 0 1", out_valid, busy, sweep_done);
    else pass_cnt++;
    step(1);
    chk_cnt++;
    if (sweep_done !== 1'b0) $display("FAIL sweep_done_width: got %b expected 0", sweep_done);
    else pass_cnt++;
    out_ready = 1'b0;
    step(1);
  endtask

  task automatic test_backpressure();
    int  base_hs;
    bit  seen;
    logic [BW-1:0] held;
    do_clr();
    for (int i = 0; i < 24; i++) do_write($urandom);
    out_ready = 1'b1;
    exp_q.push_back(exp_beat(0, 24, 1'b0));
    exp_q.push_back(exp_beat(8, 24, 1'b0));
    exp_q.push_back(exp_beat(16, 24, 1'b1));
    held    = exp_beat(8, 24, 1'b0);
    base_hs = hs_cnt;
    pulse_sweep();
    step(1);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk_cnt++;
      if ({out_valid, out_data, out_mask, out_base, out_last} !== {1'b1, held})
        $display("FAIL stall_hold_%0d: got v=%b base=%0d mask=%h last=%b", c, out_valid, out_base, out_mask, out_last);
      else pass_cnt++;
      step(1);
    end
    out_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (sweep_done) seen = 1'b1;
      else step(1);
    end
    chk_cnt++;
    if (!seen) $display("FAIL stall_sweep_done: got no sweep_done within 20 cycles");
    else pass_cnt++;
    chk_cnt++;
    if (hs_cnt - base_hs !== 3) $display("FAIL stall_beat_count: got %0d beats expected 3", hs_cnt - base_hs);
    else pass_cnt++;
    out_ready = 1'b0;
    step(2);
  endtask

  task automatic test_clr_abort();
    int done_seen;
    int valid_seen;
    do_clr();
    for (int i = 0; i < 24; i++) do_write($urandom);
    out_ready = 1'b0;
    pulse_sweep();
    chk_cnt++;
    if ({out_valid, busy} !== 2'b11) $display("FAIL abort_started: got v=%b busy=%b expected 1 1", out_valid, busy);
    else pass_cnt++;
    do_clr();
    chk_cnt++;
    if ({out_valid, busy, fill_count, empty} !== {1'b0, 1'b0, 6'd0, 1'b1})
      $display("FAIL abort_state: got v=%b busy=%b fill=%0d empty=%b expected 0 0 0 1", out_valid, busy, fill_count, empty);
    else pass_cnt++;
    out_ready  = 1'b1;
    done_seen  = 0;
    valid_seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (sweep_done) done_seen++;
      if (out_valid) valid_seen++;
      step(1);
    end
    chk_cnt++;
    if ({done_seen, valid_seen} !== {32'd0, 32'd0})
      $display("FAIL abort_quiet: got sweep_done=%0d valid=%0d cycles expected 0 0", done_seen, valid_seen);
    else pass_cnt++;
    out_ready = 1'b0;
  endtask

  task automatic test_empty_sweep();
    out_ready = 1'b1;
    pulse_sweep();
    chk_cnt++;
    if ({sweep_done, out_valid, busy} !== 3'b100)
      $display("FAIL empty_sweep: got sd=%b v=%b busy=%b expected 1 0 0", sweep_done, out_valid, busy);
    else pass_cnt++;
    step(1);
    chk_cnt++;
    if ({sweep_done, out_valid} !== 2'b00)
      $display("FAIL empty_sweep_end: got sd=%b v=%b expected 0 0", sweep_done, out_valid);
    else pass_cnt++;
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 16; i++) do_write($urandom);
    out_ready = 1'b0;
    pulse_sweep();
    chk_cnt++;
    if ({out_valid, busy, fill_count} !== {1'b1, 1'b1, 6'd16})
      $display("FAIL arst_started: got v=%b busy=%b fill=%0d expected 1 1 16", out_valid, busy, fill_count);
    else pass_cnt++;
    #3 rst = 1'b1;
    #1;
    chk_cnt++;
    if ({out_valid, out_mask, out_base, out_last, wr_done, wr_err, busy, sweep_done, full, empty, fill_count}
        !== {1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0})
      $display("FAIL arst_ctrl: got v=%b m=%h b=%0d l=%b busy=%b sd=%b empty=%b fill=%0d",
               out_valid, out_mask, out_base, out_last, busy, sweep_done, empty, fill_count);
    else pass_cnt++;
    chk_cnt++;
    if (out_data !== '0) $display("FAIL arst_data: got %h expected 0", out_data);
    else pass_cnt++;
    fill_m = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    step(2);
    chk_cnt++;
    if ({out_valid, busy, sweep_done, dbg_state} !== {1'b0, 1'b0, 1'b0, lane_burst_ram_pkg::IDLE})
      $display("FAIL arst_after: got v=%b busy=%b sd=%b state=%0d", out_valid, busy, sweep_done, dbg_state);
    else pass_cnt++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    chk_cnt     = 0;
    pass_cnt    = 0;
    hs_cnt      = 0;
    fill_m      = 0;
    rst         = 1'b1;
    clr         = 1'b0;
    wr_en       = 1'b0;
    wr_data     = '0;
    rd_req      = 1'b0;
    rd_base     = '0;
    sweep_start = 1'b0;
    out_ready   = 1'b0;

    test_reset();
    test_full();
    test_wrap_read();
    test_read_during_write();
    test_sweep_basic();
    test_backpressure();
    test_clr_abort();
    test_empty_sweep();
    test_async_reset();

    chk_cnt++;
    if (exp_q.size() != 0) $display("FAIL sb_leftover: got %0d undelivered beats expected 0", exp_q.size());
    else pass_cnt++;

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/lane_burst_ram.md
# lane_burst_ram

Parametrised append-only parameter RAM with a LANES-wide burst read port, for the collision-detection pipeline. Sphere parameter words are streamed in one per cycle. They come back either as single random-access bursts or as an automatic sweep over everything stored. The output register uses a valid/ready handshake so a stalled collision stage never loses a beat.

## Interface
- DATA_WIDTH, 32: word width.
- ADDR_WIDTH, 5: index width. The memory holds exactly RAM_DEPTH = 2**ADDR_WIDTH words (localparam).
- LANES, 8: words per burst. Must be a power of two, ≤ RAM_DEPTH.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear: sets fill_count to 0, clears wr_err, aborts any sweep. Memory contents are kept.
- wr_en  in  1  append wr_data at index fill_count.
- wr_data  in  DATA_WIDTH  write word.
- wr_done  out  1  one-cycle pulse, the cycle after an accepted write.
- wr_err  out  1  sticky. Set by a rejected write.
- fill_count  out  ADDR_WIDTH+1  number of words stored (0..RAM_DEPTH).
- full  out  1  high when fill_count == RAM_DEPTH.
- empty  out  1  high when fill_count == 0.
- rd_req  in  1  request a random burst.
- rd_base  in  ADDR_WIDTH  first word index of the burst.
- sweep_start  in  1  start a sweep over all stored words.
- out_valid  out  1  beat available.
- out_ready  in  1  consumer accepts the beat.
- out_data  out  LANES*DATA_WIDTH  lane i sits at bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_mask  out  LANES  bit i high if lane i holds a stored word.
- out_base  out  ADDR_WIDTH  base index of the current beat.
- out_last  out  1  last beat of the transfer.
- busy  out  1  high in SWEEP.
- sweep_done  out  1  one-cycle pulse after the final sweep beat is accepted.

## Operation
States:
- IDLE → SWEEP on sweep_start with fill_count > 0.
- IDLE → DONE on sweep_start with fill_count == 0.
- SWEEP → DONE when the beat with out_last handshakes.
- DONE → IDLE after one cycle. sweep_done is high in DONE.

Writes:
- Accepted when wr_en && !full && state==IDLE && !clr.
- A rejected write (full or not IDLE) sets wr_err and gives no wr_done.
- If clr and wr_en are high together, clr wins and the write is dropped silently.

Output register load rule: the register loads only when it is free, i.e. when !out_valid || out_ready.

Random read (rd_req):
- Accepted when state==IDLE, the output register is free, and sweep_start is low. sweep_start takes precedence when both are high.
- Otherwise the request is ignored; there is no queueing.
- The beat is loaded with out_base = rd_base and out_last = 1.

Lane contents:
- Lane i data = mem[(base+i) mod RAM_DEPTH]; the index wraps around.
- out_mask[i] = (base+i) < fill_count, computed unwrapped in ADDR_WIDTH+1 bits, so wrapped lanes are never masked valid.

Sweep:
- Snapshot N = fill_count at start.
- Emit ceil(N/LANES) beats with bases 0, LANES, 2·LANES, and so on.
- out_last is high on the final beat, and the final beat's mask covers only indices below N.
- Writes are rejected while the sweep runs, so the snapshot is consistent.

Abort and reset:
- clr during SWEEP: out_valid drops, state goes to IDLE, no sweep_done.
- rst clears all state immediately.

Reset values:
- out_valid, out_data, out_mask, out_base, out_last = 0.
- wr_done, wr_err, busy, sweep_done, full = 0.
- fill_count = 0; empty = 1.
- Memory contents are not reset.

## Timing
- Write is accepted at edge k. fill_count, full and empty update at edge k; wr_done is high in cycle k+1.
- Read latency is 1. A request accepted at edge k (rd_req or sweep_start) gives out_valid in cycle k+1.
- Sweep beats run back-to-back while out_ready stays high. N words take ceil(N/LANES) cycles, and sweep_done follows the last handshake by 1 cycle.
- While out_valid && !out_ready, out_data, out_mask, out_base and out_last hold stable.
- A read in the same cycle as a write returns the old memory contents.

## Structure
- Package lane_burst_ram_pkg holds:
  - the state typedef (IDLE, SWEEP, DONE);
  - function beat_count(n, lanes), which returns ceil(n/lanes).
- Sub-module multiread_ram_core holds the register-file array:
  - one write port;
  - LANES combinational read ports with modulo-RAM_DEPTH address wrap.
- Control FSM, counters and the output register live in the top level.

## Test plan
All scenarios use DATA_WIDTH=32, ADDR_WIDTH=5, LANES=8.
- Write 0xA0..0xA9, then sweep with out_ready=1 → 2 beats:
  - beat 1: base 0, mask 0xFF, data 0xA0..0xA7;
  - beat 2: base 8, mask 0x03, out_last=1;
  - sweep_done pulses 1 cycle later.
- Write 32 words → full=1, fill_count=32. A 33rd write → no wr_done, wr_err=1, fill_count stays 32.
- With 32 words stored, rd_req with rd_base=28 → lanes 0-3 = mem[28..31], lanes 4-7 = mem[0..3], mask 0x0F, out_last=1.
- Store 24 words, sweep, hold out_ready low for 3 cycles on beat 2 → beat 2 held stable throughout, exactly 3 beats delivered (bases 0, 8, 16), none lost.
- clr asserted mid-sweep → next cycle out_valid=0, busy=0, fill_count=0, empty=1, and no sweep_done ever pulses.
- Two cases:
  - sweep_start with empty memory → sweep_done pulse one cycle later, out_valid never high;
  - asynchronous rst mid-sweep → all outputs return to reset values before the next edge.
